// File: rtl/async_event_sync_if.sv
// Signal bundle for async_event_sync: raw asynchronous inputs and controls toward the
// synchroniser, filtered levels and event flags back to the CSR/interrupt side.
interface async_event_sync_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0]   i;
    logic [2*CHANNELS-1:0] edge_mode;
    logic [CHANNELS-1:0]   ack;
    logic [CHANNELS-1:0]   level;
    logic [CHANNELS-1:0]   pulse;
    logic [CHANNELS-1:0]   pending;
    logic [CHANNELS-1:0]   overrun;

    modport master (
        output i, edge_mode, ack,
        input  level, pulse, pending, overrun
    );

    modport slave (
        input  i, edge_mode, ack,
        output level, pulse, pending, overrun
    );
endinterface

// File: rtl/async_event_sync.sv
// Multi-channel asynchronous event synchroniser: flip-flop chain, glitch filter,
// selectable edge detection and sticky pending/overrun flags with per-channel ack.
module async_event_sync #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned STAGES     = 2,
    parameter int unsigned FILTER_LEN = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    async_event_sync_if.slave bus
);
    localparam int unsigned   CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [STAGES-1:0]   sync_q [CHANNELS];
    logic [CW-1:0]       cnt_q  [CHANNELS];
    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] pending_q;
    logic [CHANNELS-1:0] overrun_q;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] pulse_c;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned n = 0; n < CHANNELS; n++) sync_q[n] <= '0;
        end else begin
            for (int unsigned n = 0; n < CHANNELS; n++)
                sync_q[n] <= {sync_q[n][STAGES-2:0], bus.i[n]};
        end
    end

    always_comb begin
        s = '0;
        for (int unsigned n = 0; n < CHANNELS; n++) s[n] = sync_q[n][STAGES-1];
    end

    // A value is accepted only after holding FILTER_LEN consecutive cycles at s.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned n = 0; n < CHANNELS; n++) cnt_q[n] <= '0;
            level_q <= '0;
        end else begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                if (s[n] == level_q[n]) begin
                    cnt_q[n] <= '0;
                end else if (cnt_q[n] == CNT_LAST) begin
                    level_q[n] <= s[n];
                    cnt_q[n]   <= '0;
                end else begin
                    cnt_q[n] <= cnt_q[n] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        rise    = level_q & ~level_d;
        fall    = ~level_q & level_d;
        pulse_c = '0;
        for (int unsigned n = 0; n < CHANNELS; n++)
            pulse_c[n] = (rise[n] & bus.edge_mode[2*n]) | (fall[n] & bus.edge_mode[2*n+1]);
    end

    // An ack in the same cycle as a new event consumes the old one, so no overrun.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            level_d   <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            level_d   <= level_q;
            pending_q <= pulse_c | (pending_q & ~bus.ack);
            overrun_q <= (pulse_c & pending_q & ~bus.ack) | (overrun_q & ~bus.ack);
        end
    end

    assign bus.level   = level_q;
    assign bus.pulse   = pulse_c;
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_async_event_sync.sv
// Self-checking bench for async_event_sync: per-cycle comparison against a behavioural
// model plus directed scenarios with hand-computed expectations.
module tb_async_event_sync;
    localparam int unsigned CH = 4;
    localparam int unsigned ST = 2;
    localparam int unsigned FL = 3;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [CH-1:0] i_v = '0;
    logic [2*CH-1:0] mode_v = '0;
    logic [CH-1:0] ack_v = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    async_event_sync_if #(.CHANNELS(CH)) bus ();

    assign bus.i         = i_v;
    assign bus.edge_mode = mode_v;
    assign bus.ack       = ack_v;

    async_event_sync #(.CHANNELS(CH), .STAGES(ST), .FILTER_LEN(FL)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: delayed input history, run-length acceptance, event bookkeeping.
    bit            ipipe [CH][ST];
    bit            shist [CH][FL];
    logic [CH-1:0] m_level   = '0;
    logic [CH-1:0] m_changed = '0;
    logic [CH-1:0] m_pending = '0;
    logic [CH-1:0] m_overrun = '0;

    function automatic logic [CH-1:0] m_pulse();
        logic [CH-1:0] p;
        p = '0;
        for (int n = 0; n < CH; n++)
            p[n] = m_changed[n] & (m_level[n] ? mode_v[2*n] : mode_v[2*n+1]);
        return p;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int n = 0; n < CH; n++) begin
                for (int k = 0; k < ST; k++) ipipe[n][k] = 1'b0;
                for (int k = 0; k < FL; k++) shist[n][k] = 1'b0;
            end
            m_level = '0; m_changed = '0; m_pending = '0; m_overrun = '0;
        end else begin
            logic [CH-1:0] ev;
            ev = m_pulse();
            for (int n = 0; n < CH; n++) begin
                bit s_cur;
                bit all_diff;
                if (ack_v[n]) begin
                    m_pending[n] = 1'b0;
                    m_overrun[n] = 1'b0;
                end
                if (ev[n]) begin
                    if (m_pending[n]) m_overrun[n] = 1'b1;
                    m_pending[n] = 1'b1;
                end
                s_cur = ipipe[n][ST-1];
                for (int k = FL - 1; k > 0; k--) shist[n][k] = shist[n][k-1];
                shist[n][0] = s_cur;
                all_diff = 1'b1;
                for (int k = 0; k < FL; k++)
                    if (shist[n][k] == m_level[n]) all_diff = 1'b0;
                m_changed[n] = all_diff;
                if (all_diff) m_level[n] = ~m_level[n];
                for (int k = ST - 1; k > 0; k--) ipipe[n][k] = ipipe[n][k-1];
                ipipe[n][0] = i_v[n];
            end
        end
    end

    always @(negedge sys_clk) begin
        check("model_level",   bus.level,   m_level);
        check("model_pulse",   bus.pulse,   m_pulse());
        check("model_pending", bus.pending, m_pending);
        check("model_overrun", bus.overrun, m_overrun);
    end

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic sample();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        logic lv;

        // Reset held while the inputs toggle randomly
        repeat (6) begin
            step();
            i_v = CH'($urandom);
        end
        step(); i_v = '0;
        step(); sys_rst_n = 1'b1;
        #1;
        check("rst_level",   bus.level,   32'd0);
        check("rst_pulse",   bus.pulse,   32'd0);
        check("rst_pending", bus.pending, 32'd0);
        check("rst_overrun", bus.overrun, 32'd0);
        pc = 0;
        repeat (5) begin sample(); pc += $countones(bus.pulse); end
        check("rst_no_pulse", pc, 32'd0);

        // Rising-edge latency on ch0
        step();
        mode_v[1:0] = 2'b01;
        i_v[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            sample();
            check("lat_level",   bus.level[0],   k >= 5);
            check("lat_pulse",   bus.pulse[0],   k == 5);
            check("lat_pending", bus.pending[0], k >= 6);
        end
        step();
        i_v[0] = 1'b0;
        pc = 0;
        repeat (10) begin sample(); pc += bus.pulse[0]; end
        check("fall_no_pulse", pc, 32'd0);
        check("fall_level",    bus.level[0], 32'd0);

        // Both-edge toggle recovery on ch1
        step();
        mode_v[3:2] = 2'b11;
        pc = 0;
        for (int t = 0; t < 4; t++) begin
            i_v[1] = ~i_v[1];
            repeat (8) begin step(); pc += bus.pulse[1]; end
        end
        check("both_pulse_count", pc, 32'd4);

        // Glitch rejection on ch2
        mode_v[5:4] = 2'b01;
        i_v[2] = 1'b1;
        step(); step();
        i_v[2] = 1'b0;
        pc = 0; lv = 1'b0;
        repeat (10) begin step(); pc += bus.pulse[2]; lv |= bus.level[2]; end
        check("glitch_pulse", pc, 32'd0);
        check("glitch_level", lv, 32'd0);
        i_v[2] = 1'b1;
        step(); step(); step();
        i_v[2] = 1'b0;
        pc = 0;
        repeat (10) begin step(); pc += bus.pulse[2]; end
        check("hold3_pulse", pc, 32'd1);

        // Overrun and ack on ch3
        mode_v[7:6] = 2'b01;
        i_v[3] = 1'b1; repeat (8) step();
        i_v[3] = 1'b0; repeat (8) step();
        i_v[3] = 1'b1; repeat (8) step();
        check("ovr_pending", bus.pending[3], 32'd1);
        check("ovr_overrun", bus.overrun[3], 32'd1);
        ack_v[3] = 1'b1; step(); ack_v[3] = 1'b0;
        check("ack_pending", bus.pending[3], 32'd0);
        check("ack_overrun", bus.overrun[3], 32'd0);
        i_v[3] = 1'b0; repeat (8) step();
        i_v[3] = 1'b1; repeat (8) step();
        check("evA_pending", bus.pending[3], 32'd1);
        check("evA_overrun", bus.overrun[3], 32'd0);
        i_v[3] = 1'b0; repeat (8) step();
        i_v[3] = 1'b1;
        repeat (5) step();
        check("coinc_pulse", bus.pulse[3], 32'd1);
        ack_v[3] = 1'b1; step(); ack_v[3] = 1'b0;
        check("coinc_pending", bus.pending[3], 32'd1);
        check("coinc_overrun", bus.overrun[3], 32'd0);
        step();
        check("coinc_hold", bus.pending[3], 32'd1);

        // Reset mid-operation on ch0, one cycle after s changes
        i_v[3] = 1'b0;
        i_v[0] = 1'b1;
        step(); step(); step();
        sys_rst_n = 1'b0;
        #1;
        check("midrst_level",   bus.level,   32'd0);
        check("midrst_pulse",   bus.pulse,   32'd0);
        check("midrst_pending", bus.pending, 32'd0);
        check("midrst_overrun", bus.overrun, 32'd0);
        i_v[0] = 1'b0;
        step(); step();
        sys_rst_n = 1'b1;
        pc = 0;
        repeat (10) begin step(); pc += $countones(bus.pulse); end
        check("midrst_no_pulse", pc, 32'd0);

        @(posedge sys_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
